// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and elaboration-time helpers for the buffered UART receiver.
//   rx_state_t     : receiver FSM state encoding (PARITY state only exists
//                    when UART_RX_PARITY_EN is defined)
//   parity_mode_t  : parity selection (NONE=0, ODD=1, EVEN=2)
//   calc_divisor   : clocks per oversample tick, floor(clk / (baud * os))
//   calc_div_width : width of the tick divider counter
//   majority3      : 2-of-3 vote used for bit decisions
// Optional feature macro: UART_RX_PARITY_EN
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_mode_t;

    // A divisor below 1 would stall the tick generator; clamp it.
    function automatic int calc_divisor(input int clk_freq, input int baud_rate,
                                        input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int calc_div_width(input int divisor);
        return (divisor > 1) ? $clog2(divisor) : 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding received words. Pointers carry one extra MSB so
// full and empty can be told apart after wrap-around. A push while full is
// accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write request, push_data is the word to store
//   pop         : read request (ignored when empty)
//   head_data   : current head entry (0 while empty)
//   full, empty : occupancy status
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered
// Oversampling UART receiver with configurable frame format, per-word error
// flags and an output FIFO read through a ready/valid port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RX_IDLE   | line idle, waiting for a falling edge on synchronised rx
//   RX_START  | start bit; a high vote rejects it as a glitch
//   RX_DATA   | shifting in DATA_BITS data bits, LSB first
//   RX_PARITY | parity bit check (UART_RX_PARITY_EN builds only)
//   RX_STOP   | stop bit; word pushed at the vote, no wait for bit end
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   rx              : asynchronous serial input, idles high
//   rd_data         : head entry data
//   rd_frame_err    : head entry stop bit sampled low
//   rd_parity_err   : head entry parity mismatch (0 without the macro)
//   rd_valid        : FIFO not empty
//   rd_ready        : consumer takes the head entry
//   overrun         : 1-clk pulse when a completed word is dropped
//   busy            : FSM not idle
// Optional feature macro: UART_RX_PARITY_EN (enables PARITY handling).
// ---------------------------------------------------------------------------
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_frame_err,
    output logic                 rd_parity_err,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W   = calc_div_width(DIVISOR);
    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(DIVISOR - 1);
    localparam logic [TICK_W-1:0] TICK_SMP_A   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_SMP_B   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_VOTE    = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam parity_mode_t PAR_MODE   = parity_mode_t'(2'(PARITY));
    localparam logic         USE_PARITY = (PAR_MODE != PAR_NONE);
    localparam logic         ODD_PARITY = (PAR_MODE == PAR_ODD);
    localparam int           ENTRY_W    = DATA_BITS + 2;
`else
    localparam int           ENTRY_W    = DATA_BITS + 1;
`endif

    // input synchroniser and edge register
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic fall_edge;

    // timing
    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              at_smp_a;
    logic              at_smp_b;
    logic              at_vote;
    logic              bit_end;

    // datapath
    logic                 smp_a;
    logic                 smp_b;
    logic                 vote;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // FSM
    rx_state_t state;
    rx_state_t state_nxt;
    logic      timer_restart;
    logic      shift_en;
    logic      bit_clr;
    logic      bit_inc;
    logic      push;
    logic      frame_err;

    // FIFO
    logic [ENTRY_W-1:0] push_word;
    logic [ENTRY_W-1:0] head_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

`ifdef UART_RX_PARITY_EN
    logic par_capture;
    logic par_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall_edge = rx_prev & ~rx_sync;

    // Down-counting divider: a tick fires on terminal count and the counter
    // reloads. Restarting at the start edge aligns ticks to the frame.
    assign tick     = (div_cnt == '0);
    assign at_smp_a = tick && (tick_cnt == TICK_SMP_A);
    assign at_smp_b = tick && (tick_cnt == TICK_SMP_B);
    assign at_vote  = tick && (tick_cnt == TICK_VOTE);
    assign bit_end  = tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= '0;
        end else if (timer_restart) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt - 1'b1;
        end
    end

    // The third sample is taken live at the vote tick.
    assign vote = majority3(smp_a, smp_b, rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_restart = 1'b0;
        shift_en      = 1'b0;
        bit_clr       = 1'b0;
        bit_inc       = 1'b0;
        push          = 1'b0;
        frame_err     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture   = 1'b0;
`endif
        unique case (state)
            RX_IDLE: begin
                if (fall_edge) begin
                    state_nxt     = RX_START;
                    timer_restart = 1'b1;
                end
            end
            RX_START: begin
                if (at_vote && vote) begin
                    state_nxt = RX_IDLE;
                end else if (bit_end) begin
                    state_nxt = RX_DATA;
                    bit_clr   = 1'b1;
                end
            end
            RX_DATA: begin
                if (at_vote) shift_en = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = USE_PARITY ? RX_PARITY : RX_STOP;
`else
                        state_nxt = RX_STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (at_vote) par_capture = 1'b1;
                if (bit_end) state_nxt = RX_STOP;
            end
`endif
            RX_STOP: begin
                // Leaving at the vote lets a back-to-back start bit be seen.
                if (at_vote) begin
                    push      = 1'b1;
                    frame_err = ~vote;
                    state_nxt = RX_IDLE;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (at_smp_a) smp_a <= rx_sync;
            if (at_smp_b) smp_b <= rx_sync;
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Error when data ones plus parity bit disagree with the selected sense.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (timer_restart) begin
            par_err_q <= 1'b0;
        end else if (par_capture) begin
            par_err_q <= (^shift_reg) ^ vote ^ ODD_PARITY;
        end
    end

    assign push_word     = {par_err_q, frame_err, shift_reg};
    assign rd_parity_err = head_word[DATA_BITS+1];
`else
    assign push_word     = {frame_err, shift_reg};
    assign rd_parity_err = 1'b0;
`endif

    assign pop = rd_valid && rd_ready;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid     = ~fifo_empty;
    assign rd_data      = head_word[DATA_BITS-1:0];
    assign rd_frame_err = head_word[DATA_BITS];
    assign overrun      = push && fifo_full && !pop;
    assign busy         = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
`timescale 1ns/1ps
module tb_uart_rx_buffered;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_parity_err;
    logic       rd_valid;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int pops_seen = 0;
    int unexpected = 0;
    int overrun_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .PARITY     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .overrun       (overrun),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every accepted word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && overrun) overrun_cnt++;
        if (rst_n && rd_valid && rd_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                unexpected++;
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("sb_data",       {24'h0, rd_data},       {24'h0, mon_exp[7:0]});
                check_eq("sb_frame_err",  {31'h0, rd_frame_err},  {31'h0, mon_exp[8]});
                check_eq("sb_parity_err", {31'h0, rd_parity_err}, {31'h0, mon_exp[9]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(BIT_CLKS);
    endtask

    // Sends one frame (even parity when parity is compiled in). rx is left at
    // the stop-bit level so a low stop bit can be stretched into a break.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic bad_par, input logic expect_push);
        logic p;
        p = (^d) ^ bad_par;
        if (expect_push) exp_q.push_back({PAR_ON & bad_par, ~stop_v, d});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_ON) drive_bit(p);
        drive_bit(stop_v);
    endtask

    int pops_before;
    int ov_before;

    initial begin
        idle(5);
        check_eq("rst_rd_valid",      {31'h0, rd_valid},      0);
        check_eq("rst_rd_data",       {24'h0, rd_data},       0);
        check_eq("rst_rd_frame_err",  {31'h0, rd_frame_err},  0);
        check_eq("rst_rd_parity_err", {31'h0, rd_parity_err}, 0);
        check_eq("rst_overrun",       {31'h0, overrun},       0);
        check_eq("rst_busy",          {31'h0, busy},          0);
        rst_n = 1'b1;
        idle(20);

        // single frame held in the FIFO until read
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check_eq("a5_valid",     {31'h0, rd_valid},     1);
        check_eq("a5_data",      {24'h0, rd_data},      32'hA5);
        check_eq("a5_frame_err", {31'h0, rd_frame_err}, 0);
        check_eq("a5_par_err",   {31'h0, rd_parity_err}, 0);
        check_eq("a5_busy",      {31'h0, busy},         0);
        rd_ready = 1'b1;
        idle(10);

        // wrong then correct parity bit
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        idle(40);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        idle(40);

        // 40-clk glitch must be rejected
        pops_before = pops_seen;
        rx = 1'b0;
        idle(20);
        check_eq("glitch_busy_hi", {31'h0, busy}, 1);
        idle(20);
        rx = 1'b1;
        idle(300);
        check_eq("glitch_busy_lo",  {31'h0, busy}, 0);
        check_eq("glitch_no_push",  pops_seen, pops_before);
        check_eq("glitch_no_valid", {31'h0, rd_valid}, 0);

        // low stop bit stretched into a break, then a clean frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        idle(400);
        check_eq("break_no_restart", {31'h0, busy}, 0);
        rx = 1'b1;
        idle(50);
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        idle(20);

        // five back-to-back frames into a four-entry FIFO
        rd_ready = 1'b0;
        ov_before = overrun_cnt;
        for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1, 1'b0, d <= 4);
        idle(20);
        check_eq("fifo_overrun_once", overrun_cnt - ov_before, 1);
        check_eq("fifo_full_valid",   {31'h0, rd_valid}, 1);
        check_eq("fifo_head",         {24'h0, rd_data}, 32'h01);
        rd_ready = 1'b1;
        idle(10);
        check_eq("fifo_drained", exp_q.size(), 0);
        check_eq("fifo_empty",   {31'h0, rd_valid}, 0);

        // reset in the middle of the data bits of 0x7E
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_eq("midframe_busy", {31'h0, busy}, 1);
        rst_n = 1'b0;
        idle(3);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(2);
        check_eq("rst_mid_valid", {31'h0, rd_valid}, 0);
        check_eq("rst_mid_busy",  {31'h0, busy}, 0);
        idle(200);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        idle(20);

        check_eq("sb_leftover",   exp_q.size(), 0);
        check_eq("sb_unexpected", unexpected, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
